fetch_stage: RTL and testbench
==============================

Name: fetch_stage

Overview:
- F-stage of the 5-stage MIPS pipeline: holds the fetch PC and the F/D pipeline register.
- Each cycle it takes the next-PC value computed from F/D state and drives F_PC to instruction memory and the next-PC logic.
- Captures the fetched instruction, fetch-address exception code and delay-slot flag into D.
- Handles stall, exception/interrupt redirection to the handler, and eret squash.

Parameters:
- RESET_PC, 32'h0000_3000, PC value after reset.
- HANDLER_PC, 32'h0000_4180, exception/interrupt entry address.
- IM_BASE, 32'h0000_3000, lowest legal fetch address.
- IM_LIMIT, 32'h0000_6FFF, highest legal fetch byte address.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous reset, active-high.
- next_PC  in  32  next fetch address from next-PC logic (already selects EPC for eret).
- stall  in  1  D-stage hazard stall: hold F_PC and the whole F/D register.
- req  in  1  exception/interrupt request from CP0 (M stage): redirect and flush.
- eret_D  in  1  instruction in D is eret: squash the instruction now in F.
- branch_jump_D  in  1  instruction in D is a branch/jump; F instruction is its delay slot.
- instr_F  in  32  instruction word read from IM at F_PC.
- F_PC  out  32  current fetch PC.
- D_PC  out  32  PC of instruction in D.
- D_instr  out  32  instruction in D.
- D_excode  out  5  fetch exception code carried to D (0 = none, 4 = AdEL).
- D_BD  out  1  D instruction is in a branch delay slot.

Behaviour:
- All state updates on the posedge of clk. Priority: reset > req > stall > eret_D > normal.
- Reset: F_PC <= RESET_PC; D_PC <= RESET_PC; D_instr <= 0; D_excode <= 0; D_BD <= 0.
- req:
  - F_PC <= HANDLER_PC.
  - D_PC <= HANDLER_PC; D_instr <= 0; D_excode <= 0; D_BD <= 0 (bubble).
  - Applies regardless of stall.
- Stall (req=0): every register holds its value. next_PC, instr_F and eret_D are ignored.
- eret_D (req=0, stall=0):
  - F_PC <= next_PC.
  - D_PC <= F_PC; D_instr <= 0; D_excode <= 0; D_BD <= 0. eret has no delay slot.
- Normal:
  - F_PC <= next_PC; D_PC <= F_PC; D_BD <= branch_jump_D.
  - Fetch check on current F_PC: fault if F_PC[1:0] != 0, F_PC < IM_BASE, or F_PC > IM_LIMIT.
  - On fault: D_instr <= 0 (nop substituted, instr_F discarded) and D_excode <= 4.
  - Otherwise: D_instr <= instr_F and D_excode <= 0.
- Range compare is unsigned on the full 32 bits. No wrap handling: 0xFFFF_FFFC is simply out of range.
- A faulting PC still advances: F_PC <= next_PC. Redirection happens only when CP0 raises req later.
- Latency: an instruction appears in D exactly one cycle after its address is on F_PC, plus one cycle per stall cycle.
- F_PC output equals the register; no combinational path from inputs to outputs.
- Reset asserted mid-stall or mid-req overrides both in the same cycle.

Test Plan:
- Reset for 2 cycles, then release with next_PC = F_PC+4 and IM returning F_PC as data. Required: F_PC = 0x3000, 0x3004, 0x3008; after the first edge D_PC = 0x3000, D_instr = 0x3000, D_excode = 0, D_BD = 0.
- stall=1 for 3 cycles at F_PC = 0x3008, D_PC = 0x3004. Required: all outputs frozen. After release, D_PC = 0x3008 and F_PC = next_PC.
- branch_jump_D=1 with F_PC = 0x3010. Required: next cycle D_PC = 0x3010, D_BD = 1. With branch_jump_D=0 the following cycle: D_BD = 0.
- Misaligned fetch, F_PC = 0x3002. Required: D_excode = 4, D_instr = 0, D_PC = 0x3002. Repeat with out-of-range F_PC = 0x7000 (excode 4) and in-range 0x6FFC (excode 0).
- req=1 together with stall=1 at F_PC = 0x3020. Required: F_PC = 0x4180, D_PC = 0x4180, D_instr = 0, D_BD = 0, D_excode = 0.
- eret_D=1 with next_PC = EPC = 0x3040 and F_PC = 0x4190. Required: F_PC = 0x3040, D_PC = 0x4190, D_instr = 0. Next cycle D_PC = 0x3040 and D_instr = instr_F.

Source files
------------

// File: rtl/fetch_stage.sv
// MIPS fetch stage: fetch PC register plus the F/D pipeline register.
// An instruction reaches D one cycle after its PC is on F_PC; stall holds everything, req redirects and flushes.
module fetch_stage #(
  parameter logic [31:0] RESET_PC   = 32'h0000_3000,
  parameter logic [31:0] HANDLER_PC = 32'h0000_4180,
  parameter logic [31:0] IM_BASE    = 32'h0000_3000,
  parameter logic [31:0] IM_LIMIT   = 32'h0000_6FFF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] next_PC,
  input  logic        stall,
  input  logic        req,
  input  logic        eret_D,
  input  logic        branch_jump_D,
  input  logic [31:0] instr_F,
  output logic [31:0] F_PC,
  output logic [31:0] D_PC,
  output logic [31:0] D_instr,
  output logic [4:0]  D_excode,
  output logic        D_BD
);

  localparam logic [4:0] EXC_NONE = 5'd0;
  localparam logic [4:0] EXC_ADEL = 5'd4;

  logic fetch_fault;

  // Unsigned full-width bounds check; addresses past the top of the space are just out of range.
  assign fetch_fault = (F_PC[1:0] != 2'b00) || (F_PC < IM_BASE) || (F_PC > IM_LIMIT);

  always_ff @(posedge clk) begin
    if (reset) begin
      F_PC     <= RESET_PC;
      D_PC     <= RESET_PC;
      D_instr  <= 32'h0;
      D_excode <= EXC_NONE;
      D_BD     <= 1'b0;
    end else if (req) begin
      F_PC     <= HANDLER_PC;
      D_PC     <= HANDLER_PC;
      D_instr  <= 32'h0;
      D_excode <= EXC_NONE;
      D_BD     <= 1'b0;
    end else if (!stall) begin
      F_PC <= next_PC;
      D_PC <= F_PC;
      if (eret_D) begin
        // eret has no delay slot: the instruction behind it is squashed to a nop.
        D_instr  <= 32'h0;
        D_excode <= EXC_NONE;
        D_BD     <= 1'b0;
      end else begin
        D_BD <= branch_jump_D;
        if (fetch_fault) begin
          D_instr  <= 32'h0;
          D_excode <= EXC_ADEL;
        end else begin
          D_instr  <= instr_F;
          D_excode <= EXC_NONE;
        end
      end
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: stimulus pushes expected post-edge state, a monitor pops and compares.
module tb_fetch_stage;

  logic        clk;
  logic        reset;
  logic [31:0] next_PC;
  logic        stall;
  logic        req;
  logic        eret_D;
  logic        branch_jump_D;
  logic [31:0] instr_F;
  logic [31:0] F_PC;
  logic [31:0] D_PC;
  logic [31:0] D_instr;
  logic [4:0]  D_excode;
  logic        D_BD;

  fetch_stage dut (
    .clk           (clk),
    .reset         (reset),
    .next_PC       (next_PC),
    .stall         (stall),
    .req           (req),
    .eret_D        (eret_D),
    .branch_jump_D (branch_jump_D),
    .instr_F       (instr_F),
    .F_PC          (F_PC),
    .D_PC          (D_PC),
    .D_instr       (D_instr),
    .D_excode      (D_excode),
    .D_BD          (D_BD)
  );

  typedef struct {
    string       nm;
    logic [31:0] f_pc;
    logic [31:0] d_pc;
    logic [31:0] d_instr;
    logic [4:0]  d_excode;
    logic        d_bd;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  bit   done  = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string nm, input string fld, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s.%s: got 0x%08h expected 0x%08h", nm, fld, act, exp);
    end
  endtask

  // Monitor: the registers present new state every edge; compare against the entry queued for that edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk(e.nm, "F_PC",     F_PC,             e.f_pc);
        chk(e.nm, "D_PC",     D_PC,             e.d_pc);
        chk(e.nm, "D_instr",  D_instr,          e.d_instr);
        chk(e.nm, "D_excode", {27'h0, D_excode}, {27'h0, e.d_excode});
        chk(e.nm, "D_BD",     {31'h0, D_BD},     {31'h0, e.d_bd});
      end
    end
  end

  task automatic step(input logic r, input logic s, input logic q, input logic er, input logic bj,
                      input logic [31:0] npc, input logic [31:0] ins,
                      input logic [31:0] ef, input logic [31:0] ed, input logic [31:0] ei,
                      input logic [4:0] ex, input logic bd, input string nm);
    exp_t e;
    @(negedge clk);
    reset = r; stall = s; req = q; eret_D = er; branch_jump_D = bj;
    next_PC = npc; instr_F = ins;
    e.nm = nm; e.f_pc = ef; e.d_pc = ed; e.d_instr = ei; e.d_excode = ex; e.d_bd = bd;
    exp_q.push_back(e);
  endtask

  initial begin
    reset = 1'b1; stall = 1'b0; req = 1'b0; eret_D = 1'b0; branch_jump_D = 1'b0;
    next_PC = 32'h0; instr_F = 32'h0;

    //    rst  stl  req  eret bj    next_PC       instr_F        F_PC          D_PC          D_instr       exc  bd
    step(1, 0, 0, 0, 0, 32'h0000_1234, 32'hDEAD_BEEF, 32'h0000_3000, 32'h0000_3000, 32'h0,          0, 0, "reset0");
    step(1, 0, 0, 0, 0, 32'h0000_1234, 32'hDEAD_BEEF, 32'h0000_3000, 32'h0000_3000, 32'h0,          0, 0, "reset1");
    step(0, 0, 0, 0, 0, 32'h0000_3004, 32'h0000_3000, 32'h0000_3004, 32'h0000_3000, 32'h0000_3000, 0, 0, "run0");
    step(0, 0, 0, 0, 0, 32'h0000_3008, 32'h0000_3004, 32'h0000_3008, 32'h0000_3004, 32'h0000_3004, 0, 0, "run1");
    // Stall: inputs that would otherwise change state must all be ignored.
    for (int i = 0; i < 3; i++)
      step(0, 1, 0, 1, 1, 32'h0000_BAD0, 32'hBAD1_BAD1, 32'h0000_3008, 32'h0000_3004, 32'h0000_3004, 0, 0,
           $sformatf("stall%0d", i));
    step(0, 0, 0, 0, 0, 32'h0000_300C, 32'h0000_3008, 32'h0000_300C, 32'h0000_3008, 32'h0000_3008, 0, 0, "unstall");
    step(0, 0, 0, 0, 0, 32'h0000_3010, 32'h0000_300C, 32'h0000_3010, 32'h0000_300C, 32'h0000_300C, 0, 0, "run2");
    step(0, 0, 0, 0, 1, 32'h0000_3014, 32'h0000_3010, 32'h0000_3014, 32'h0000_3010, 32'h0000_3010, 0, 1, "bd_set");
    step(0, 0, 0, 0, 0, 32'h0000_3002, 32'h0000_3014, 32'h0000_3002, 32'h0000_3014, 32'h0000_3014, 0, 0, "bd_clr");
    step(0, 0, 0, 0, 0, 32'h0000_7000, 32'h1234_5678, 32'h0000_7000, 32'h0000_3002, 32'h0,          4, 0, "misalign");
    step(0, 0, 0, 0, 0, 32'h0000_6FFC, 32'h1111_1111, 32'h0000_6FFC, 32'h0000_7000, 32'h0,          4, 0, "above_lim");
    step(0, 0, 0, 0, 0, 32'h0000_2FFC, 32'h2222_2222, 32'h0000_2FFC, 32'h0000_6FFC, 32'h2222_2222, 0, 0, "top_word");
    step(0, 0, 0, 0, 1, 32'h0000_3020, 32'h4444_4444, 32'h0000_3020, 32'h0000_2FFC, 32'h0,          4, 1, "below_base");
    step(0, 1, 1, 0, 1, 32'h0000_3024, 32'h5555_5555, 32'h0000_4180, 32'h0000_4180, 32'h0,          0, 0, "req_stall");
    step(0, 0, 0, 0, 0, 32'h0000_4184, 32'h6666_6666, 32'h0000_4184, 32'h0000_4180, 32'h6666_6666, 0, 0, "handler0");
    step(0, 0, 0, 0, 0, 32'h0000_4188, 32'h7777_7777, 32'h0000_4188, 32'h0000_4184, 32'h7777_7777, 0, 0, "handler1");
    step(0, 0, 0, 0, 0, 32'h0000_4190, 32'h7878_7878, 32'h0000_4190, 32'h0000_4188, 32'h7878_7878, 0, 0, "handler2");
    step(0, 0, 0, 1, 1, 32'h0000_3040, 32'h8888_8888, 32'h0000_3040, 32'h0000_4190, 32'h0,          0, 0, "eret");
    step(0, 0, 0, 0, 0, 32'h0000_3044, 32'h9999_9999, 32'h0000_3044, 32'h0000_3040, 32'h9999_9999, 0, 0, "after_eret");
    step(1, 1, 1, 0, 0, 32'h0000_3048, 32'hAAAA_AAAA, 32'h0000_3000, 32'h0000_3000, 32'h0,          0, 0, "reset_over");

    @(negedge clk);
    for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(negedge clk);
    if (exp_q.size() > 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
    end
    done = 1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    repeat (5000) @(posedge clk);
    if (!done) begin
      n_cmp++;
      n_bad++;
      $display("FAIL watchdog: cycle budget expired, got timeout expected completion");
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
    end
  end

endmodule
